gray2rgb_packer: RTL and testbench

GRAY2RGB_PACKER -- requirements
Module: gray2rgb_packer

---
 rtl/gray2rgb_pkg.sv | 31 +++
 rtl/gray2rgb_packer_if.sv | 26 ++
 rtl/pixel_word_fifo.sv | 49 ++++
 rtl/gray2rgb_packer.sv | 159 +++++++++++++++
 tb/tb_gray2rgb_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray2rgb_pkg.sv
// Shared types and constants for the gray-to-RGB packer: FSM states, output
// word layout and the pixel mapping (invert, then optional threshold).
package gray2rgb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;
  localparam int RES_W      = 2;
  localparam int WORD_W     = 37;

  typedef struct packed {
    logic        last;
    logic [3:0]  be;
    logic [31:0] data;
  } word_t;

  // 255-G is the bitwise complement of an 8-bit value.
  function automatic logic [7:0] map_pixel(input logic [7:0] g,
                                           input bit         invert,
                                           input logic [7:0] threshold);
    logic [7:0] v;
    v = invert ? ~g : g;
    if (threshold != 8'd0) v = (v >= threshold) ? 8'hFF : 8'h00;
    return v;
  endfunction

endpackage

// File: rtl/gray2rgb_packer_if.sv
// Pixel-in / word-out stream bundle used to hook a source and sink to the packer.
//
// Handshake: on both streams a beat transfers on a rising clock edge where
// valid and ready are both high; while valid is high and ready is low the
// source keeps its payload unchanged, and ready never waits on valid.
interface gray2rgb_packer_if;
  logic        gray_valid;
  logic [7:0]  gray_data;
  logic        gray_last;
  logic        gray_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic        word_last;
  logic        word_ready;

  modport master (
    output gray_valid, gray_data, gray_last, word_ready,
    input  gray_ready, word_valid, word_data, word_be, word_last
  );

  modport slave (
    input  gray_valid, gray_data, gray_last, word_ready,
    output gray_ready, word_valid, word_data, word_be, word_last
  );
endinterface

// File: rtl/pixel_word_fifo.sv
// Two-entry output word FIFO (data+be+last); a push and a pop on the same
// edge are both honoured when full, leaving the count unchanged.
module pixel_word_fifo
  import gray2rgb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  word_t            push_word,
  input  logic             pop,
  output word_t            head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  word_t mem [FIFO_DEPTH];
  logic  rd_ptr;
  logic  wr_ptr;
  logic  do_push;
  logic  do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_FULL) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gray2rgb_packer.sv
// Expands gray pixels to R=G=B byte triplets and packs the byte stream into
// little-endian 32-bit words, with a padded final word at end of frame.
module gray2rgb_packer
  import gray2rgb_pkg::*;
#(
  parameter bit         INVERT    = 1'b0,
  parameter logic [7:0] THRESHOLD = 8'h00
) (
  input  logic        Clk_i,
  input  logic        RstN_i,
  input  logic        GrayValid_i,
  input  logic [7:0]  GrayData_i,
  input  logic        GrayLast_i,
  output logic        GrayReady_o,
  output logic        WordValid_o,
  output logic [31:0] WordData_o,
  output logic [3:0]  WordBe_o,
  output logic        WordLast_o,
  input  logic        WordReady_i,
  output state_e      dbg_state
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  state_e             state_q, state_d;
  logic [RES_W-1:0]   r_q, r_d;
  logic [23:0]        res_q, res_d;
  word_t              flush_q, flush_d;
  logic               active_q;

  logic [7:0]         pix;
  logic               accept;
  logic               has_full;
  logic [31:0]        full_word;
  logic [23:0]        carry;
  logic [RES_W-1:0]   carry_r;
  logic [3:0]         pad_be;
  word_t              pad_word;

  logic               push;
  word_t              push_word;
  logic               pop;
  word_t              head;
  logic [CNT_W-1:0]   fifo_count;

  assign pix    = map_pixel(GrayData_i, INVERT, THRESHOLD);
  // Ready depends only on registered state, so WordReady_i never reaches it.
  assign GrayReady_o = active_q && (state_q == RUN) && (fifo_count < CNT_FULL);
  assign accept      = GrayValid_i && GrayReady_o;

  // Residual bytes plus three copies of the pixel: at most one full word,
  // the rest is carried (and becomes the padded word on a last pixel).
  always_comb begin
    has_full  = 1'b0;
    full_word = '0;
    carry     = '0;
    carry_r   = '0;
    pad_be    = 4'b0000;
    case (r_q)
      2'd0: begin
        carry   = {pix, pix, pix};
        carry_r = 2'd3;
        pad_be  = 4'b0111;
      end
      2'd1: begin
        has_full  = 1'b1;
        full_word = {pix, pix, pix, res_q[7:0]};
      end
      2'd2: begin
        has_full  = 1'b1;
        full_word = {pix, pix, res_q[15:0]};
        carry     = {16'h0000, pix};
        carry_r   = 2'd1;
        pad_be    = 4'b0001;
      end
      default: begin
        has_full  = 1'b1;
        full_word = {pix, res_q};
        carry     = {8'h00, pix, pix};
        carry_r   = 2'd2;
        pad_be    = 4'b0011;
      end
    endcase
  end

  assign pad_word = '{last: 1'b1, be: pad_be, data: {8'h00, carry}};

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    res_d     = res_q;
    flush_d   = flush_q;
    push      = 1'b0;
    push_word = '0;
    if (state_q == RUN) begin
      if (accept && GrayLast_i) begin
        r_d   = '0;
        res_d = '0;
        push  = 1'b1;
        if (has_full && (carry_r != '0)) begin
          push_word = '{last: 1'b0, be: 4'b1111, data: full_word};
          flush_d   = pad_word;
          state_d   = FLUSH;
        end else if (has_full) begin
          push_word = '{last: 1'b1, be: 4'b1111, data: full_word};
        end else begin
          push_word = pad_word;
        end
      end else if (accept) begin
        r_d       = carry_r;
        res_d     = carry;
        push      = has_full;
        push_word = '{last: 1'b0, be: 4'b1111, data: full_word};
      end
    end else begin
      if (fifo_count < CNT_FULL) begin
        push      = 1'b1;
        push_word = flush_q;
        flush_d   = '0;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state_q  <= RUN;
      r_q      <= '0;
      res_q    <= '0;
      flush_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      res_q    <= res_d;
      flush_q  <= flush_d;
      active_q <= 1'b1;
    end
  end

  assign pop = WordValid_o && WordReady_i;

  pixel_word_fifo u_fifo (
    .clk       (Clk_i),
    .rst_n     (RstN_i),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign WordValid_o = (fifo_count != '0);
  assign WordData_o  = head.data;
  assign WordBe_o    = head.be;
  assign WordLast_o  = head.last;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray2rgb_packer.sv
// Bench for gray2rgb_packer: default, INVERT=1 and THRESHOLD=0x80 instances
// share one input stream; a byte-queue model predicts the words of each.
module tb_gray2rgb_packer;
  import gray2rgb_pkg::*;

  logic clk;
  logic rst_n;
  int   ready_mode;
  int   n_checks;
  int   n_fail;

  gray2rgb_packer_if bus ();

  logic        ready_inv, valid_inv, last_inv;
  logic [31:0] data_inv;
  logic [3:0]  be_inv;
  logic        ready_thr, valid_thr, last_thr;
  logic [31:0] data_thr;
  logic [3:0]  be_thr;
  state_e      st_main, st_inv, st_thr;

  logic [7:0]  byte_q[3][$];
  logic [36:0] exp_q[3][$];
  logic [36:0] got_q[3][$];

  gray2rgb_packer dut (
    .Clk_i(clk), .RstN_i(rst_n),
    .GrayValid_i(bus.gray_valid), .GrayData_i(bus.gray_data), .GrayLast_i(bus.gray_last),
    .GrayReady_o(bus.gray_ready), .WordValid_o(bus.word_valid), .WordData_o(bus.word_data),
    .WordBe_o(bus.word_be), .WordLast_o(bus.word_last), .WordReady_i(bus.word_ready),
    .dbg_state(st_main)
  );

  gray2rgb_packer #(.INVERT(1'b1), .THRESHOLD(8'h00)) dut_inv (
    .Clk_i(clk), .RstN_i(rst_n),
    .GrayValid_i(bus.gray_valid), .GrayData_i(bus.gray_data), .GrayLast_i(bus.gray_last),
    .GrayReady_o(ready_inv), .WordValid_o(valid_inv), .WordData_o(data_inv),
    .WordBe_o(be_inv), .WordLast_o(last_inv), .WordReady_i(bus.word_ready),
    .dbg_state(st_inv)
  );

  gray2rgb_packer #(.INVERT(1'b0), .THRESHOLD(8'h80)) dut_thr (
    .Clk_i(clk), .RstN_i(rst_n),
    .GrayValid_i(bus.gray_valid), .GrayData_i(bus.gray_data), .GrayLast_i(bus.gray_last),
    .GrayReady_o(ready_thr), .WordValid_o(valid_thr), .WordData_o(data_thr),
    .WordBe_o(be_thr), .WordLast_o(last_thr), .WordReady_i(bus.word_ready),
    .dbg_state(st_thr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Sink ready: 0 = stalled, 1 = always ready, otherwise random each cycle.
  initial begin
    bus.word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.word_ready = 1'b0;
        1:       bus.word_ready = 1'b1;
        default: bus.word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xform(input logic [7:0] g, input int k);
    if (k == 1) return 8'hFF - g;
    if (k == 2) return (g >= 8'h80) ? 8'hFF : 8'h00;
    return g;
  endfunction

  task automatic model_pixel(input logic [7:0] g, input logic last);
    for (int k = 0; k < 3; k++) begin
      logic [7:0]  b;
      logic [36:0] w;
      int          n;
      b = xform(g, k);
      repeat (3) byte_q[k].push_back(b);
      while (byte_q[k].size() >= 4) begin
        w = '0;
        w[35:32] = 4'hF;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_q[k].pop_front();
        if (last && byte_q[k].size() == 0) w[36] = 1'b1;
        exp_q[k].push_back(w);
      end
      if (last && byte_q[k].size() != 0) begin
        w = '0;
        n = byte_q[k].size();
        for (int i = 0; i < n; i++) begin
          w[8*i +: 8] = byte_q[k].pop_front();
          w[32+i]     = 1'b1;
        end
        w[36] = 1'b1;
        exp_q[k].push_back(w);
      end
    end
  endtask

  // Monitor: handshakes are sampled mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gray_valid && bus.gray_ready) model_pixel(bus.gray_data, bus.gray_last);
      if (bus.word_valid && bus.word_ready) begin
        got_q[0].push_back({bus.word_last, bus.word_be, bus.word_data});
        got_q[1].push_back({last_inv, be_inv, data_inv});
        got_q[2].push_back({last_thr, be_thr, data_thr});
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_got(input string name, input int k, input int idx, input logic [36:0] exp);
    logic [63:0] act;
    act = (idx < got_q[k].size()) ? 64'(got_q[k][idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
    chk(name, act, 64'(exp));
  endtask

  task automatic compare_sb(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_count"}, 64'(got_q[k].size()), 64'(exp_q[k].size()));
      while (got_q[k].size() > 0 && exp_q[k].size() > 0)
        chk({tag, "_word"}, 64'(got_q[k].pop_front()), 64'(exp_q[k].pop_front()));
      got_q[k].delete();
      exp_q[k].delete();
      byte_q[k].delete();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [7:0] g, input logic last);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    bus.gray_valid = 1'b1;
    bus.gray_data  = g;
    bus.gray_last  = last;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = bus.gray_ready;
      waited++;
      @(posedge clk);
      #1;
    end
    bus.gray_valid = 1'b0;
    bus.gray_last  = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.word_valid && bus.gray_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) chk({tag, "_idle_timeout"}, 64'(done), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  g;
    logic [31:0] m;
    logic [31:0] i;
    logic [31:0] t;
  } vec_t;

  vec_t vecs[5];
  int   n_acc;

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    ready_mode = 0;
    rst_n = 1'b0;
    bus.gray_valid = 1'b0;
    bus.gray_data  = 8'h00;
    bus.gray_last  = 1'b0;

    vecs[0] = '{8'hAB, 32'h00ABABAB, 32'h00545454, 32'h00FFFFFF};
    vecs[1] = '{8'h00, 32'h00000000, 32'h00FFFFFF, 32'h00000000};
    vecs[2] = '{8'h7F, 32'h007F7F7F, 32'h00808080, 32'h00000000};
    vecs[3] = '{8'h80, 32'h00808080, 32'h007F7F7F, 32'h00FFFFFF};
    vecs[4] = '{8'hFF, 32'h00FFFFFF, 32'h00000000, 32'h00FFFFFF};

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_word_valid", 64'(bus.word_valid), 64'd0);
    chk("rst_word_data",  64'(bus.word_data),  64'd0);
    chk("rst_word_be",    64'(bus.word_be),    64'd0);
    chk("rst_word_last",  64'(bus.word_last),  64'd0);
    chk("rst_gray_ready", 64'(bus.gray_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(bus.gray_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 64'(bus.gray_ready), 64'd1);
    ready_mode = 1;

    // Four pixels -> three full words, last on the third
    send_pixel(8'h10, 1'b0);
    send_pixel(8'h20, 1'b0);
    chk("latency_valid", 64'(bus.word_valid), 64'd1);
    chk("latency_data",  64'(bus.word_data),  64'h20101010);
    send_pixel(8'h30, 1'b0);
    send_pixel(8'h40, 1'b1);
    wait_idle("four");
    check_got("four_w0", 0, 0, {1'b0, 4'hF, 32'h20101010});
    check_got("four_w1", 0, 1, {1'b0, 4'hF, 32'h30302020});
    check_got("four_w2", 0, 2, {1'b1, 4'hF, 32'h40404030});
    compare_sb("four");

    // Single-pixel frames for all three parameter sets
    for (int v = 0; v < 5; v++) begin
      send_pixel(vecs[v].g, 1'b1);
      wait_idle("single");
      check_got("single_main", 0, 0, {1'b1, 4'b0111, vecs[v].m});
      check_got("single_inv",  1, 0, {1'b1, 4'b0111, vecs[v].i});
      check_got("single_thr",  2, 0, {1'b1, 4'b0111, vecs[v].t});
      compare_sb("single");
    end

    // Last pixel producing full + padded word goes through FLUSH
    send_pixel(8'h01, 1'b0);
    send_pixel(8'h02, 1'b1);
    chk("flush_ready", 64'(bus.gray_ready), 64'd0);
    chk("flush_state", 64'(st_main), 64'(FLUSH));
    chk("flush_state_inv", 64'(st_inv), 64'(FLUSH));
    chk("flush_state_thr", 64'(st_thr), 64'(FLUSH));
    wait_idle("flush");
    check_got("flush_w0", 0, 0, {1'b0, 4'hF, 32'h02010101});
    check_got("flush_w1", 0, 1, {1'b1, 4'b0011, 32'h00000202});
    compare_sb("flush");

    // Threshold / invert on a two-pixel frame
    send_pixel(8'h7F, 1'b0);
    send_pixel(8'h80, 1'b1);
    wait_idle("thr");
    check_got("thr_main_w0", 0, 0, {1'b0, 4'hF, 32'h807F7F7F});
    check_got("thr_main_w1", 0, 1, {1'b1, 4'b0011, 32'h00008080});
    check_got("thr_inv_w0",  1, 0, {1'b0, 4'hF, 32'h7F808080});
    check_got("thr_inv_w1",  1, 1, {1'b1, 4'b0011, 32'h00007F7F});
    check_got("thr_thr_w0",  2, 0, {1'b0, 4'hF, 32'hFF000000});
    check_got("thr_thr_w1",  2, 1, {1'b1, 4'b0011, 32'h0000FFFF});
    compare_sb("thr");

    // Sink stalled for five cycles under continuous input
    ready_mode = 0;
    send_pixel(8'h11, 1'b0);
    send_pixel(8'h22, 1'b0);
    send_pixel(8'h33, 1'b0);
    bus.gray_valid = 1'b1;
    bus.gray_data  = 8'h44;
    bus.gray_last  = 1'b0;
    n_acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.gray_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepts", 64'(n_acc), 64'd0);
    chk("stall_ready",   64'(bus.gray_ready), 64'd0);
    chk("stall_valid",   64'(bus.word_valid), 64'd1);
    chk("stall_popped",  64'(got_q[0].size()), 64'd0);
    ready_mode = 1;
    send_pixel(8'h44, 1'b0);
    send_pixel(8'h55, 1'b1);
    wait_idle("stall");
    check_got("stall_w0", 0, 0, {1'b0, 4'hF, 32'h22111111});
    check_got("stall_w1", 0, 1, {1'b0, 4'hF, 32'h33332222});
    check_got("stall_w2", 0, 2, {1'b0, 4'hF, 32'h44444433});
    check_got("stall_w3", 0, 3, {1'b1, 4'b0111, 32'h00555555});
    compare_sb("stall");

    // Random frames with a randomly stalling sink
    ready_mode = 2;
    for (int f = 0; f < 24; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int p = 0; p < len; p++) begin
        send_pixel(8'($urandom_range(0, 255)), (p == len - 1));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    ready_mode = 1;
    wait_idle("rand");
    compare_sb("rand");
    chk("idle_valid_inv", 64'(valid_inv), 64'd0);
    chk("idle_ready_thr", 64'(ready_thr), 64'd1);

    // Reset in the middle of a frame
    ready_mode = 0;
    send_pixel(8'h11, 1'b0);
    send_pixel(8'h22, 1'b0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      byte_q[k].delete();
      exp_q[k].delete();
      got_q[k].delete();
    end
    #1;
    chk("midrst_valid", 64'(bus.word_valid), 64'd0);
    chk("midrst_data",  64'(bus.word_data),  64'd0);
    chk("midrst_ready", 64'(bus.gray_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", 64'(bus.gray_ready), 64'd1);
    ready_mode = 1;
    send_pixel(8'h10, 1'b0);
    send_pixel(8'h20, 1'b0);
    send_pixel(8'h30, 1'b0);
    send_pixel(8'h40, 1'b1);
    wait_idle("realign");
    check_got("realign_w0", 0, 0, {1'b0, 4'hF, 32'h20101010});
    check_got("realign_w1", 0, 1, {1'b0, 4'hF, 32'h30302020});
    check_got("realign_w2", 0, 2, {1'b1, 4'hF, 32'h40404030});
    compare_sb("realign");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
